rr_result_load_arbiter: RTL and testbench

//  Shares one loadable result register (async-clear, load-enabled 8-bit capture) among NUM_REQ requesters.
//  A round-robin arbiter picks one pending request per grant slot, drives the load strobe and data,
//  and captures the data into the result register. It then holds the result for HOLD_CYCLES.

---
 rtl/rr_result_load_arbiter.sv | 157 +++++++++++++++
 tb/tb_rr_result_load_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_result_load_arbiter.sv
// rtl/rr_result_load_arbiter.sv - round-robin arbiter sharing one load-enabled result register
// Optional build macro RR_ARB_FLUSH_EN adds a synchronous active-high flush input.
module rr_result_load_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int HOLD_CYCLES = 2,
  localparam int PTR_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
`ifdef RR_ARB_FLUSH_EN
  input  logic                      flush,
`endif
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      mode,
  output logic [DATA_W-1:0]         extra_sum,
  output logic [DATA_W-1:0]         extra_result,
  output logic [PTR_W-1:0]          result_owner,
  output logic                      result_valid,
  output logic                      busy
);

  // Counter only ever holds HOLD_CYCLES-1 down to 0.
  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_INIT = (HOLD_CYCLES > 0) ? CNT_W'(HOLD_CYCLES - 1) : '0;
  localparam logic [PTR_W:0] NUM_REQ_W = (PTR_W + 1)'(NUM_REQ);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [PTR_W-1:0]    owner_q, owner_d;
  logic                valid_q, valid_d;

  logic                flush_w;
  logic                win_found;
  logic [PTR_W-1:0]    win_idx;
  logic [PTR_W:0]      cand;
  logic [PTR_W:0]      ptr_inc;
  logic [PTR_W-1:0]    ptr_next;
  logic                grant_en;

`ifdef RR_ARB_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  // Find the first pending request scanning upward from the pointer, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = {1'b0, ptr_q} + (PTR_W + 1)'(off);
      if (cand >= NUM_REQ_W) begin
        cand = cand - NUM_REQ_W;
      end
      if (!win_found && req[cand[PTR_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[PTR_W-1:0];
      end
    end
  end

  // Pointer moves to the requester just after the winner, modulo NUM_REQ.
  always_comb begin
    ptr_inc = {1'b0, win_idx} + 1'b1;
    if (ptr_inc == NUM_REQ_W) begin
      ptr_inc = '0;
    end
    ptr_next = ptr_inc[PTR_W-1:0];
  end

  // A grant only happens in IDLE, out of reset, with no flush pending.
  assign grant_en = rst_n && (state_q == IDLE) && win_found && !flush_w;

  // One-hot grant and the winner's data presented to the result register.
  always_comb begin
    gnt       = '0;
    extra_sum = '0;
    if (grant_en) begin
      gnt[win_idx] = 1'b1;
      extra_sum    = req_data[win_idx*DATA_W +: DATA_W];
    end
  end

  assign mode         = grant_en;
  assign busy         = (state_q == HOLD);
  assign extra_result = result_q;
  assign result_owner = owner_q;
  assign result_valid = valid_q;

  // Next-state logic: load on grant, then count down the hold window.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    owner_d  = owner_q;
    valid_d  = valid_q;
    if (flush_w) begin
      state_d  = IDLE;
      ptr_d    = '0;
      cnt_d    = '0;
      result_d = '0;
      owner_d  = '0;
      valid_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_found) begin
            result_d = extra_sum;
            owner_d  = win_idx;
            valid_d  = 1'b1;
            ptr_d    = ptr_next;
            if (HOLD_CYCLES > 0) begin
              state_d = HOLD;
              cnt_d   = HOLD_INIT;
            end
          end
        end
        HOLD: begin
          if (cnt_q == '0) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      endcase
    end
  end

  // State and result registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      owner_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      owner_q  <= owner_d;
      valid_q  <= valid_d;
    end
  end

endmodule

// File: tb/tb_rr_result_load_arbiter.sv
// tb/tb_rr_result_load_arbiter.sv - bench for rr_result_load_arbiter (HOLD_CYCLES 2 and 0 instances)
module tb_rr_result_load_arbiter;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;

  logic [3:0] gnt_o   [2];
  logic       mode_o  [2];
  logic [7:0] sum_o   [2];
  logic [7:0] res_o   [2];
  logic [1:0] own_o   [2];
  logic       valid_o [2];
  logic       busy_o  [2];

  int checks = 0;
  int errors = 0;

  int         m_ptr   [2];
  int         m_hold  [2];
  int         m_own   [2];
  logic [7:0] m_res   [2];
  logic       m_valid [2];

  logic [3:0] e_gnt   [2];
  logic       e_mode  [2];
  logic [7:0] e_sum   [2];
  logic [7:0] e_res   [2];
  logic [1:0] e_own   [2];
  logic       e_valid [2];
  logic       e_busy  [2];

  always #5 clk = ~clk;

  rr_result_load_arbiter #(.NUM_REQ(4), .DATA_W(8), .HOLD_CYCLES(2)) u_hold2 (
    .clk(clk), .rst_n(rst_n),
`ifdef RR_ARB_FLUSH_EN
    .flush(flush),
`endif
    .req(req), .req_data(req_data), .gnt(gnt_o[0]), .mode(mode_o[0]),
    .extra_sum(sum_o[0]), .extra_result(res_o[0]), .result_owner(own_o[0]),
    .result_valid(valid_o[0]), .busy(busy_o[0])
  );

  rr_result_load_arbiter #(.NUM_REQ(4), .DATA_W(8), .HOLD_CYCLES(0)) u_hold0 (
    .clk(clk), .rst_n(rst_n),
`ifdef RR_ARB_FLUSH_EN
    .flush(flush),
`endif
    .req(req), .req_data(req_data), .gnt(gnt_o[1]), .mode(mode_o[1]),
    .extra_sum(sum_o[1]), .extra_result(res_o[1]), .result_owner(own_o[1]),
    .result_valid(valid_o[1]), .busy(busy_o[1])
  );

  function automatic int hold_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_ptr[d] = 0; m_hold[d] = 0; m_own[d] = 0; m_res[d] = '0; m_valid[d] = 1'b0;
    end
  endtask

  // Drive one cycle of inputs, sample at the falling edge, record expectations, advance the model.
  task automatic step(input logic [3:0] r, input logic [31:0] dat, input logic f);
    @(posedge clk);
    #1;
    req = r; req_data = dat; flush = f;
    #4;
    for (int d = 0; d < 2; d++) begin
      int w;
      w = pick(r, m_ptr[d]);
      e_res[d]   = m_res[d];
      e_own[d]   = 2'(m_own[d]);
      e_valid[d] = m_valid[d];
      e_busy[d]  = (m_hold[d] > 0);
      if (rst_n && !f && m_hold[d] == 0 && w >= 0) begin
        e_gnt[d] = 4'(1 << w);
        e_sum[d] = dat[w*8 +: 8];
      end else begin
        e_gnt[d] = '0;
        e_sum[d] = '0;
      end
      e_mode[d] = (e_gnt[d] != '0);
      if (!rst_n || f) begin
        m_ptr[d] = 0; m_hold[d] = 0; m_own[d] = 0; m_res[d] = '0; m_valid[d] = 1'b0;
      end else if (m_hold[d] > 0) begin
        m_hold[d] = m_hold[d] - 1;
      end else if (w >= 0) begin
        m_res[d] = dat[w*8 +: 8]; m_own[d] = w; m_valid[d] = 1'b1;
        m_ptr[d] = (w + 1) % N; m_hold[d] = hold_of(d);
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    step(4'b0000, 32'h0, 1'b0);
    step(4'b0000, 32'h0, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    for (int t = 0; t < 6; t++) begin
      step((t == 5) ? 4'b1111 : 4'b0000, 32'hDEADBEEF, 1'b0);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (gnt_o[d] !== 4'b0 || mode_o[d] !== 1'b0 || sum_o[d] !== 8'h0) begin
          errors++;
          $display("FAIL reset_gnt dut%0d t%0d: gnt=%b mode=%b sum=%h required 0/0/00", d, t, gnt_o[d], mode_o[d], sum_o[d]);
        end
        checks++;
        if (res_o[d] !== 8'h0 || own_o[d] !== 2'd0 || valid_o[d] !== 1'b0 || busy_o[d] !== 1'b0) begin
          errors++;
          $display("FAIL reset_regs dut%0d t%0d: res=%h own=%0d valid=%b busy=%b required all 0", d, t, res_o[d], own_o[d], valid_o[d], busy_o[d]);
        end
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_two_req();
    logic [3:0] gx [8] = '{4'b0001, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
    logic [7:0] rx [8] = '{8'h00, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h11};
    logic [1:0] ox [8] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd2, 2'd0};
    logic       bx [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    do_reset();
    for (int t = 0; t < 8; t++) begin
      step(4'b0101, 32'h0022_0011, 1'b0);
      checks++;
      if (gnt_o[0] !== gx[t] || busy_o[0] !== bx[t]) begin
        errors++;
        $display("FAIL two_req_gnt t%0d: gnt=%b busy=%b required %b/%b", t, gnt_o[0], busy_o[0], gx[t], bx[t]);
      end
      checks++;
      if (res_o[0] !== rx[t] || own_o[0] !== ox[t]) begin
        errors++;
        $display("FAIL two_req_result t%0d: res=%h own=%0d required %h/%0d", t, res_o[0], own_o[0], rx[t], ox[t]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] dv [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_reset();
    for (int t = 0; t < 5; t++) begin
      step(4'b1111, 32'h4433_2211, 1'b0);
      checks++;
      if (gnt_o[1] !== 4'(1 << (t % 4)) || busy_o[1] !== 1'b0 || sum_o[1] !== dv[t % 4]) begin
        errors++;
        $display("FAIL b2b_gnt t%0d: gnt=%b busy=%b sum=%h required %b/0/%h", t, gnt_o[1], busy_o[1], sum_o[1], 4'(1 << (t % 4)), dv[t % 4]);
      end
      if (t > 0) begin
        checks++;
        if (res_o[1] !== dv[t - 1] || own_o[1] !== 2'(t - 1)) begin
          errors++;
          $display("FAIL b2b_result t%0d: res=%h own=%0d required %h/%0d", t, res_o[1], own_o[1], dv[t - 1], t - 1);
        end
      end
    end
  endtask

  task automatic test_hold_queue();
    logic [3:0] rq [5] = '{4'b0010, 4'b1000, 4'b1000, 4'b1000, 4'b0000};
    logic [3:0] gx [5] = '{4'b0010, 4'b0000, 4'b0000, 4'b1000, 4'b0000};
    logic [7:0] rx [5] = '{8'h00, 8'hA5, 8'hA5, 8'hA5, 8'h3C};
    logic       bx [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    do_reset();
    for (int t = 0; t < 5; t++) begin
      step(rq[t], 32'h3C00_A500, 1'b0);
      checks++;
      if (gnt_o[0] !== gx[t] || busy_o[0] !== bx[t] || res_o[0] !== rx[t]) begin
        errors++;
        $display("FAIL hold_queue t%0d: gnt=%b busy=%b res=%h required %b/%b/%h", t, gnt_o[0], busy_o[0], res_o[0], gx[t], bx[t], rx[t]);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(4'b0100, 32'h005A_0000, 1'b0);
    step(4'b0000, 32'h0, 1'b0);
    checks++;
    if (res_o[0] !== 8'h5A || busy_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL arst_pre: res=%h busy=%b required 5a/1", res_o[0], busy_o[0]);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (res_o[0] !== 8'h0 || valid_o[0] !== 1'b0 || busy_o[0] !== 1'b0 || gnt_o[0] !== 4'b0) begin
      errors++;
      $display("FAIL arst_clear: res=%h valid=%b busy=%b gnt=%b required 00/0/0/0000", res_o[0], valid_o[0], busy_o[0], gnt_o[0]);
    end
    model_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    step(4'b1010, 32'h7700_6600, 1'b0);
    checks++;
    if (gnt_o[0] !== 4'b0010 || sum_o[0] !== 8'h66) begin
      errors++;
      $display("FAIL arst_first_grant: gnt=%b sum=%h required 0010/66", gnt_o[0], sum_o[0]);
    end
  endtask

`ifdef RR_ARB_FLUSH_EN
  task automatic test_flush();
    do_reset();
    step(4'b0100, 32'h0099_0000, 1'b0);
    step(4'b0000, 32'h0, 1'b0);
    step(4'b0000, 32'h0, 1'b0);
    step(4'b0010, 32'h0000_BB00, 1'b1);
    checks++;
    if (gnt_o[0] !== 4'b0 || mode_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL flush_gnt: gnt=%b mode=%b required 0000/0", gnt_o[0], mode_o[0]);
    end
    step(4'b0010, 32'h0000_BB00, 1'b0);
    checks++;
    if (res_o[0] !== 8'h0 || valid_o[0] !== 1'b0 || gnt_o[0] !== 4'b0010 || sum_o[0] !== 8'hBB) begin
      errors++;
      $display("FAIL flush_after: res=%h valid=%b gnt=%b sum=%h required 00/0/0010/bb", res_o[0], valid_o[0], gnt_o[0], sum_o[0]);
    end
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int t = 0; t < 400; t++) begin
      logic [3:0]  r;
      logic [31:0] dv;
      logic        f;
      r  = 4'($urandom) & 4'($urandom);
      dv = $urandom;
`ifdef RR_ARB_FLUSH_EN
      f = ($urandom_range(0, 15) == 0);
`else
      f = 1'b0;
`endif
      step(r, dv, f);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (gnt_o[d] !== e_gnt[d] || mode_o[d] !== e_mode[d] || sum_o[d] !== e_sum[d]) begin
          errors++;
          $display("FAIL rand_grant dut%0d t%0d: gnt=%b mode=%b sum=%h required %b/%b/%h", d, t, gnt_o[d], mode_o[d], sum_o[d], e_gnt[d], e_mode[d], e_sum[d]);
        end
        checks++;
        if (res_o[d] !== e_res[d] || own_o[d] !== e_own[d] || valid_o[d] !== e_valid[d] || busy_o[d] !== e_busy[d]) begin
          errors++;
          $display("FAIL rand_state dut%0d t%0d: res=%h own=%0d valid=%b busy=%b required %h/%0d/%b/%b", d, t, res_o[d], own_o[d], valid_o[d], busy_o[d], e_res[d], e_own[d], e_valid[d], e_busy[d]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_two_req();
    test_back_to_back();
    test_hold_queue();
    test_async_reset();
`ifdef RR_ARB_FLUSH_EN
    test_flush();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
